// File: rtl/mschd_ctrl.sv
// mschd_ctrl: SHA-256 message-schedule sequencer driving the mschdpath load/update strobes
module mschd_ctrl #(
  parameter int ROUNDS = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             hold,
  input  logic             abort,
  output logic             ld_mreg,
  output logic             upd_mreg,
  output logic             w_valid,
  output logic [5:0]       t,
  output logic             last,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [5:0] t_n;
  logic consume, accept, fin;
  // Handshake, datapath strobes and next-state selection; abort wins over accept/consume
  always_comb begin
    w_valid = ~rst & (state == RUN);
    consume = w_valid & ~hold;
    last = w_valid & (t == 6'(ROUNDS - 1));
    fin = consume & last & ~abort;
    blk_ready = ~rst & ~abort & ((state == IDLE) | (consume & last));
    accept = blk_valid & blk_ready;
    ld_mreg = accept;
    upd_mreg = accept | (consume & ~last & ~abort);
    state_n = state;
    t_n = t;
    if (abort) begin
      state_n = IDLE;
      t_n = '0;
    end else if (accept) begin
      state_n = RUN;
      t_n = '0;
    end else if (fin) begin
      state_n = IDLE;
      t_n = '0;
    end else if (consume) begin
      t_n = t + 6'd1;
    end
  end
  // State, round index, completion pulse and block counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      done <= 1'b0;
      blk_cnt <= '0;
    end else begin
      state <= state_n;
      t <= t_n;
      done <= fin;
      blk_cnt <= blk_cnt + CNT_W'(fin);
    end
  end
endmodule

// File: tb/tb_mschd_ctrl.sv
// tb_mschd_ctrl: table, directed and random checks of mschd_ctrl against a round-counting model
module tb_mschd_ctrl;
  localparam int R = 64;
  localparam int CW = 2;
  localparam int CMOD = 1 << CW;
  logic clk = 1'b0, rst = 1'b1, blk_valid = 1'b0, hold = 1'b0, abort = 1'b0;
  logic blk_ready, ld_mreg, upd_mreg, w_valid, last, done;
  logic [5:0] t;
  logic [CW-1:0] blk_cnt;
  mschd_ctrl #(.ROUNDS(R), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .hold(hold),
    .abort(abort), .ld_mreg(ld_mreg), .upd_mreg(upd_mreg), .w_valid(w_valid), .t(t),
    .last(last), .done(done), .blk_cnt(blk_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit r, bv, h, a;
    bit wv, rdy, ld, upd, lst, dn;
    int tt;
  } vec_t;
  vec_t tbl[11];
  vec_t cur;
  bit use_tbl = 0, chk = 0;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit m_busy = 0, m_done = 0;
  int m_t = 0, m_cnt = 0;
  int done_cyc = -1, done_n = 0, last_cyc = -1, ll_cyc = -1, ll_n = 0;
  bit o_ld, o_wv;
  int o_t;
  int cnt_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit bv, input bit h, input bit a);
    bit e_wv, e_last, e_cons, e_rdy, e_acc, e_upd, e_fin;
    cyc++;
    rst = r;
    blk_valid = bv;
    hold = h;
    abort = a;
    #4;
    e_wv = !r && m_busy;
    e_last = e_wv && (m_t == R - 1);
    e_cons = e_wv && !h;
    e_rdy = !r && !a && (!m_busy || (e_last && !h));
    e_acc = bv && e_rdy;
    e_fin = e_cons && e_last && !a;
    e_upd = e_acc || (e_cons && !e_last && !a);
    o_ld = ld_mreg;
    o_wv = w_valid;
    o_t = int'(t);
    if (done === 1'b1) begin
      done_cyc = cyc;
      done_n++;
      cnt_q.push_back(int'(blk_cnt));
    end
    if (last === 1'b1) last_cyc = cyc;
    if ((ld_mreg & last) === 1'b1) begin
      ll_cyc = cyc;
      ll_n++;
    end
    if (chk) begin
      cmp("w_valid", w_valid, e_wv);
      cmp("last", last, e_last);
      cmp("blk_ready", blk_ready, e_rdy);
      cmp("ld_mreg", ld_mreg, e_acc);
      cmp("upd_mreg", upd_mreg, e_upd);
      cmp("t", t, m_t);
      cmp("done", done, m_done);
      cmp("blk_cnt", blk_cnt, m_cnt);
    end
    if (use_tbl) begin
      cmp("tbl_w_valid", w_valid, cur.wv);
      cmp("tbl_blk_ready", blk_ready, cur.rdy);
      cmp("tbl_ld_mreg", ld_mreg, cur.ld);
      cmp("tbl_upd_mreg", upd_mreg, cur.upd);
      cmp("tbl_last", last, cur.lst);
      cmp("tbl_done", done, cur.dn);
      cmp("tbl_t", t, cur.tt);
    end
    if (r) begin
      m_busy = 0; m_t = 0; m_done = 0; m_cnt = 0;
    end else if (a) begin
      m_busy = 0; m_t = 0; m_done = 0;
    end else begin
      m_done = e_fin;
      if (e_fin) m_cnt = (m_cnt + 1) % CMOD;
      if (e_acc) begin
        m_busy = 1; m_t = 0;
      end else if (e_fin) begin
        m_busy = 0; m_t = 0;
      end else if (e_cons) m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit r, bv, h, a, wv, rdy, ld, upd, lst, dn, input int tt);
    vec_t v;
    v.r = r; v.bv = bv; v.h = h; v.a = a;
    v.wv = wv; v.rdy = rdy; v.ld = ld; v.upd = upd; v.lst = lst; v.dn = dn; v.tt = tt;
    return v;
  endfunction

  initial begin
    int k, s5, s63, d0, drop;
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    tbl[6]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step(1, 0, 0, 0);
    chk = 1;
    use_tbl = 1;
    for (int i = 0; i < 11; i++) begin
      cur = tbl[i];
      step(cur.r, cur.bv, cur.h, cur.a);
    end
    use_tbl = 0;
    k = cyc + 1;
    step(0, 1, 0, 0);
    d0 = done_n;
    for (int i = 0; i < 70; i++) step(0, 0, 0, 0);
    cmp("single_last_cycle", last_cyc, k + R);
    cmp("single_done_cycle", done_cyc, k + R + 1);
    cmp("single_done_pulses", done_n - d0, 1);
    cmp("single_blk_cnt", blk_cnt, 1);
    k = cyc + 1;
    step(0, 1, 0, 0);
    s5 = 0;
    s63 = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_busy && m_t == 5 && s5 < 3) begin
        s5++;
        step(0, 0, 1, 0);
        cmp("stall_t5_held", o_t, 5);
      end else if (m_busy && m_t == R - 1 && s63 < 1) begin
        s63++;
        step(0, 0, 1, 0);
      end else step(0, 0, 0, 0);
    end
    cmp("stall_done_cycle", done_cyc, k + R + 1 + 4);
    cmp("stall_blk_cnt", blk_cnt, 2);
    k = cyc + 1;
    drop = 0;
    ll_n = 0;
    d0 = done_n;
    for (int i = 0; i < 129; i++) begin
      step(0, 1, 0, 0);
      if (i >= 1 && o_wv !== 1'b1) drop++;
    end
    cmp("b2b_wvalid_drops", drop, 0);
    cmp("b2b_ld_at_last_cycle", ll_cyc, k + 2 * R);
    cmp("b2b_ld_at_last_count", ll_n, 2);
    step(0, 1, 0, 0);
    cmp("b2b_new_block_t0", o_t, 0);
    cmp("b2b_done_count", done_n - d0, 2);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    while (m_busy && m_t != 20 && cyc < 100000) step(0, 0, 0, 0);
    d0 = done_n;
    step(0, 1, 0, 1);
    cmp("abort_no_accept", o_ld, 0);
    step(0, 0, 0, 0);
    cmp("abort_idle_next", o_wv, 0);
    for (int i = 0; i < 70; i++) step(0, 0, 0, 0);
    cmp("abort_no_done", done_n - d0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    cmp("abort_restart_wv", o_wv, 1);
    cmp("abort_restart_t0", o_t, 0);
    while (m_busy && m_t != 30 && cyc < 100000) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    cmp("rst_wvalid", o_wv, 0);
    step(0, 1, 0, 0);
    cmp("rst_accept_after", o_ld, 1);
    step(1, 0, 0, 0);
    cnt_q.delete();
    for (int b = 0; b < 5; b++) begin
      step(0, 1, 0, 0);
      for (int i = 0; i < R; i++) step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    cmp("wrap_count", cnt_q.size(), 5);
    for (int i = 0; i < 5; i++)
      cmp("wrap_seq", (i < cnt_q.size()) ? cnt_q[i] : -1, (i + 1) % CMOD);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
